// File: rtl/t_rot_pkg.sv
// Shared definitions for the T_Rot target-recovery path.
// Holds the search FSM state type, the default operand width shared with the
// magnitude comparator, and the {L,E,G} flag encodings with a validity helper.
package t_rot_pkg;

   localparam int WIDTH_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PROBE  = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   // Flag vector order is {L, E, G}; a legal comparator answer is exactly one of these.
   localparam int         FLAG_W = 3;
   localparam logic [2:0] FLAG_L = 3'b100;
   localparam logic [2:0] FLAG_E = 3'b010;
   localparam logic [2:0] FLAG_G = 3'b001;

   function automatic logic flag_is_onehot(input logic [FLAG_W-1:0] flags);
      return (flags == FLAG_L) || (flags == FLAG_E) || (flags == FLAG_G);
   endfunction

endpackage

// File: rtl/sar_target_search_if.sv
// Bundle between the target-search controller and its environment.
//   start          request a new search
//   L, E, G        comparator flags (trial <, ==, > target)
//   trial          operand A driven to the comparator
//   result         recovered target, held until the next accepted start
//   busy           search in progress
//   done           one-cycle pulse when result is valid
//   err            sticky illegal-flag indication
// master: the search controller. slave: the comparator / requester side.
interface sar_target_search_if #(
   parameter int WIDTH = t_rot_pkg::WIDTH_DEF
) ();

   logic             start;
   logic             L;
   logic             E;
   logic             G;
   logic [WIDTH-1:0] trial;
   logic [WIDTH-1:0] result;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      input  start, L, E, G,
      output trial, result, busy, done, err
   );

   modport slave (
      output start, L, E, G,
      input  trial, result, busy, done, err
   );

endinterface

// File: rtl/flag_onehot_chk.sv
// Combinational validity check of a comparator {L,E,G} flag vector.
//   flags  in  {L,E,G}
//   valid  out high when exactly one flag is set
module flag_onehot_chk
   import t_rot_pkg::*;
(
   input  logic [FLAG_W-1:0] flags,
   output logic              valid
);

   assign valid = flag_is_onehot(flags);

endmodule

// File: rtl/sar_target_search.sv
// Successive-approximation search of an unknown comparator operand B.
// Drives trial values on operand A, samples the {L,E,G} answer CMP_LAT+1
// cycles after each trial update and builds the target MSB first.
//   clk, rst   clock and synchronous active-high reset
//   bus        master side of sar_target_search_if (start, flags in;
//              trial, result, busy, done, err out)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; result/err/trial hold their last values
// ST_PROBE  | trial on the comparator; flags sampled when cnt == CMP_LAT
// ST_FINISH | done pulse cycle; start ignored; back to ST_IDLE
module sar_target_search
   import t_rot_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int CMP_LAT    = 0,
   parameter int EARLY_EXIT = 1
) (
   input  logic clk,
   input  logic rst,
   sar_target_search_if.master bus
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CNT_W = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;

   localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CMP_LAT);
   localparam logic [WIDTH-1:0] TRIAL_MSB = WIDTH'(1) << (WIDTH - 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0] trial, trial_nxt;
   logic [WIDTH-1:0] result, result_nxt;
   logic             busy, busy_nxt;
   logic             done, done_nxt;
   logic             err, err_nxt;

   logic             flags_ok;
   logic             sample;
   logic [WIDTH-1:0] bit_mask;
   logic [WIDTH-1:0] acc_keep;

   flag_onehot_chk u_flag_chk (
      .flags ({bus.L, bus.E, bus.G}),
      .valid (flags_ok)
   );

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      cnt_nxt    = cnt;
      acc_nxt    = acc;
      trial_nxt  = trial;
      result_nxt = result;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      err_nxt    = err;

      sample   = (state == ST_PROBE) && (cnt == CNT_LAST);
      bit_mask = WIDTH'(1) << idx;
      // acc already has bit idx clear, so a G answer simply leaves it alone.
      acc_keep = bus.G ? acc : (acc | bit_mask);

      unique case (state)
         ST_IDLE: begin
            if (bus.start) begin
               state_nxt = ST_PROBE;
               acc_nxt   = '0;
               idx_nxt   = IDX_TOP;
               cnt_nxt   = '0;
               err_nxt   = 1'b0;
               trial_nxt = TRIAL_MSB;
               busy_nxt  = 1'b1;
            end
         end

         ST_PROBE: begin
            if (!sample) begin
               cnt_nxt = cnt + CNT_W'(1);
            end else if (!flags_ok) begin
               err_nxt    = 1'b1;
               result_nxt = acc;
               state_nxt  = ST_FINISH;
               busy_nxt   = 1'b0;
               done_nxt   = 1'b1;
            end else if ((EARLY_EXIT != 0) && bus.E) begin
               result_nxt = trial;
               state_nxt  = ST_FINISH;
               busy_nxt   = 1'b0;
               done_nxt   = 1'b1;
            end else if (idx == '0) begin
               acc_nxt    = acc_keep;
               result_nxt = acc_keep;
               state_nxt  = ST_FINISH;
               busy_nxt   = 1'b0;
               done_nxt   = 1'b1;
            end else begin
               acc_nxt   = acc_keep;
               idx_nxt   = idx - IDX_W'(1);
               trial_nxt = acc_keep | (bit_mask >> 1);
               cnt_nxt   = '0;
            end
         end

         ST_FINISH: begin
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         idx    <= IDX_TOP;
         cnt    <= '0;
         acc    <= '0;
         trial  <= '0;
         result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         cnt    <= cnt_nxt;
         acc    <= acc_nxt;
         trial  <= trial_nxt;
         result <= result_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
         err    <= err_nxt;
      end
   end

   assign bus.trial  = trial;
   assign bus.result = result;
   assign bus.busy   = busy;
   assign bus.done   = done;
   assign bus.err    = err;

endmodule

// File: tb/tb_sar_target_search.sv
// Bench for sar_target_search: three instances (CMP_LAT=0/EE=1, CMP_LAT=0/EE=0,
// CMP_LAT=2/EE=1) share start/rst/target, each with its own comparator model.
// A plan-based reference (binary search over the target) predicts every output
// on every cycle; directed runs pin the reference with literal expectations.
module tb_sar_target_search;

   localparam int W = 5;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic start = 1'b0;

   always #5 clk = ~clk;

   sar_target_search_if #(.WIDTH(W)) bus0 ();
   sar_target_search_if #(.WIDTH(W)) bus1 ();
   sar_target_search_if #(.WIDTH(W)) bus2 ();

   sar_target_search #(.WIDTH(W), .CMP_LAT(0), .EARLY_EXIT(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   sar_target_search #(.WIDTH(W), .CMP_LAT(0), .EARLY_EXIT(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   sar_target_search #(.WIDTH(W), .CMP_LAT(2), .EARLY_EXIT(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   logic [2:0]   flg [3];
   logic [W-1:0] a_trial [3];
   logic [W-1:0] a_result [3];
   logic         a_busy [3];
   logic         a_done [3];
   logic         a_err [3];

   assign bus0.start = start;
   assign bus1.start = start;
   assign bus2.start = start;
   assign {bus0.L, bus0.E, bus0.G} = flg[0];
   assign {bus1.L, bus1.E, bus1.G} = flg[1];
   assign {bus2.L, bus2.E, bus2.G} = flg[2];

   assign a_trial[0] = bus0.trial;   assign a_result[0] = bus0.result;
   assign a_trial[1] = bus1.trial;   assign a_result[1] = bus1.result;
   assign a_trial[2] = bus2.trial;   assign a_result[2] = bus2.result;
   assign a_busy[0]  = bus0.busy;    assign a_done[0] = bus0.done;   assign a_err[0] = bus0.err;
   assign a_busy[1]  = bus1.busy;    assign a_done[1] = bus1.done;   assign a_err[1] = bus1.err;
   assign a_busy[2]  = bus2.busy;    assign a_done[2] = bus2.done;   assign a_err[2] = bus2.err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t0       = 0;

   logic [W-1:0] tgt = '0;
   bit           glitch_en = 1'b0;
   bit           bad_req   = 1'b0;

   // reference model state
   bit           m_active [3];
   int           m_pos [3];
   int           m_T [3];
   logic [W-1:0] m_res [3];
   bit           m_err [3];
   bit           m_bad [3];
   logic [W-1:0] p_trial [3][W];
   logic [W-1:0] e_trial [3];
   logic [W-1:0] e_result [3];
   bit           e_busy [3];
   bit           e_done [3];
   bit           e_err [3];
   logic [W-1:0] hist [3][3];

   int lg_trial [3][32];
   int lg_result [3][32];
   int lg_busy [3][32];
   int lg_done [3][32];
   int lg_err [3][32];

   function automatic int lat_of(input int i);
      return (i == 2) ? 2 : 0;
   endfunction

   function automatic int ee_of(input int i);
      return (i == 1) ? 0 : 1;
   endfunction

   task automatic chk(input string nm, input int i, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s inst%0d cycle %0d: got %0d, expected %0d", nm, i, cyc, act, exp);
      end
   endtask

   // Binary search over the target: list of probes, final result, error flag.
   task automatic make_plan(input int i);
      logic [W-1:0] acc;
      logic [W-1:0] t;
      int           k;
      acc      = '0;
      k        = 0;
      m_res[i] = '0;
      m_err[i] = 1'b0;
      m_bad[i] = bad_req;
      for (int b = W - 1; b >= 0; b--) begin
         t = acc | (W'(1) << b);
         p_trial[i][k] = t;
         k++;
         if (bad_req) begin
            m_err[i] = 1'b1;
            m_res[i] = acc;
            break;
         end
         if (ee_of(i) == 1 && t == tgt) begin
            m_res[i] = t;
            break;
         end
         if (t <= tgt) acc = t;
         m_res[i] = acc;
      end
      m_T[i] = k * (lat_of(i) + 1) + 1;
   endtask

   task automatic apply(input int i);
      int j;
      int span;
      j    = m_pos[i];
      span = lat_of(i) + 1;
      if (j < m_T[i] - 1) begin
         e_busy[i]  = 1'b1;
         e_done[i]  = 1'b0;
         e_err[i]   = 1'b0;
         e_trial[i] = p_trial[i][j / span];
      end else begin
         e_busy[i]   = 1'b0;
         e_done[i]   = 1'b1;
         e_result[i] = m_res[i];
         e_err[i]    = m_err[i];
      end
   endtask

   task automatic model_update();
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_active[i] = 1'b0;
            e_trial[i]  = '0;
            e_result[i] = '0;
            e_busy[i]   = 1'b0;
            e_done[i]   = 1'b0;
            e_err[i]    = 1'b0;
         end else if (!m_active[i]) begin
            e_done[i] = 1'b0;
            if (start) begin
               make_plan(i);
               m_active[i] = 1'b1;
               m_pos[i]    = 0;
               apply(i);
            end
         end else begin
            m_pos[i]++;
            if (m_pos[i] == m_T[i]) begin
               m_active[i] = 1'b0;
               e_done[i]   = 1'b0;
            end else begin
               apply(i);
            end
         end
      end
   endtask

   task automatic compare_and_drive();
      int           r;
      int           lat;
      bit           samp;
      logic [W-1:0] t;
      logic [2:0]   f;
      for (int i = 0; i < 3; i++) begin
         chk("trial",  i, int'(a_trial[i]),  int'(e_trial[i]));
         chk("result", i, int'(a_result[i]), int'(e_result[i]));
         chk("busy",   i, int'(a_busy[i]),   int'(e_busy[i]));
         chk("done",   i, int'(a_done[i]),   int'(e_done[i]));
         chk("err",    i, int'(a_err[i]),    int'(e_err[i]));
         r = cyc - t0;
         if (r >= 0 && r < 32) begin
            lg_trial[i][r]  = int'(a_trial[i]);
            lg_result[i][r] = int'(a_result[i]);
            lg_busy[i][r]   = int'(a_busy[i]);
            lg_done[i][r]   = int'(a_done[i]);
            lg_err[i][r]    = int'(a_err[i]);
         end
         // comparator with lat_of(i) register stages on the trial path
         lat = lat_of(i);
         hist[i][2] = hist[i][1];
         hist[i][1] = hist[i][0];
         hist[i][0] = a_trial[i];
         t = hist[i][lat];
         f = (t < tgt) ? 3'b100 : ((t == tgt) ? 3'b010 : 3'b001);
         samp = m_active[i] && (m_pos[i] < m_T[i] - 1) && ((m_pos[i] % (lat + 1)) == lat);
         if (samp && m_bad[i] && m_pos[i] == lat) f = 3'b101;
         else if (!samp && glitch_en) f = 3'($urandom_range(0, 7));
         flg[i] = f;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
      cyc++;
      compare_and_drive();
   endtask

   function automatic int count_done(input int i);
      int n;
      n = 0;
      for (int r = 1; r < 32; r++) n += lg_done[i][r];
      return n;
   endfunction

   function automatic int first_done(input int i);
      for (int r = 1; r < 32; r++) if (lg_done[i][r] != 0) return r;
      return -1;
   endfunction

   task automatic run(input int target, input bit glitch, input bit bad,
                      input int xs_a, input int xs_b, input int rst_at);
      int w;
      tgt       = W'(target);
      glitch_en = glitch;
      bad_req   = bad;
      tick();
      for (int i = 0; i < 3; i++) begin
         for (int r = 0; r < 32; r++) begin
            lg_trial[i][r] = 0; lg_result[i][r] = 0; lg_busy[i][r] = 0;
            lg_done[i][r] = 0;  lg_err[i][r] = 0;
         end
      end
      t0    = cyc;
      start = 1'b1;
      for (int r = 1; r <= 26; r++) begin
         tick();
         start = (r == xs_a) || (r == xs_b);
         rst   = (r == rst_at);
      end
      start = 1'b0;
      rst   = 1'b0;
      w = 0;
      while ((m_active[0] || m_active[1] || m_active[2]) && w < 80) begin
         tick();
         w++;
      end
      n_checks++;
      if (w >= 80) begin
         n_fail++;
         $display("FAIL idle_wait: search still active after %0d cycles, required idle", w);
      end
      glitch_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         flg[i] = 3'b000;
         m_active[i] = 1'b0; m_pos[i] = 0; m_T[i] = 0; m_res[i] = '0;
         m_err[i] = 1'b0; m_bad[i] = 1'b0;
         e_trial[i] = '0; e_result[i] = '0; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_err[i] = 1'b0;
         for (int k = 0; k < 3; k++) hist[i][k] = '0;
         for (int k = 0; k < W; k++) p_trial[i][k] = '0;
      end

      rst = 1'b1;
      repeat (3) tick();
      chk("reset_trial", 0, int'(a_trial[0]), 0);
      chk("reset_busy",  2, int'(a_busy[2]), 0);
      rst = 1'b0;
      tick();

      // target 20, glitching flags on non-sample cycles
      run(20, 1'b1, 1'b0, 0, 0, 0);
      chk("t20_trial_c1", 0, lg_trial[0][1], 16);
      chk("t20_trial_c2", 0, lg_trial[0][2], 24);
      chk("t20_trial_c3", 0, lg_trial[0][3], 20);
      chk("t20_busy_c1",  0, lg_busy[0][1], 1);
      chk("t20_busy_c3",  0, lg_busy[0][3], 1);
      chk("t20_busy_c4",  0, lg_busy[0][4], 0);
      chk("t20_done_cyc", 0, first_done(0), 4);
      chk("t20_done_cnt", 0, count_done(0), 1);
      chk("t20_result",   0, lg_result[0][4], 20);
      chk("t20_err",      0, lg_err[0][4], 0);
      chk("t20_lat2_done_cyc", 2, first_done(2), 10);
      chk("t20_lat2_result",   2, lg_result[2][10], 20);

      // full-width probing without early exit
      run(19, 1'b0, 1'b0, 0, 0, 0);
      chk("t19_ee0_trial_c1", 1, lg_trial[1][1], 16);
      chk("t19_ee0_trial_c2", 1, lg_trial[1][2], 24);
      chk("t19_ee0_trial_c3", 1, lg_trial[1][3], 20);
      chk("t19_ee0_trial_c4", 1, lg_trial[1][4], 18);
      chk("t19_ee0_trial_c5", 1, lg_trial[1][5], 19);
      chk("t19_ee0_done_cyc", 1, first_done(1), 6);
      chk("t19_ee0_result",   1, lg_result[1][6], 19);

      run(0, 1'b0, 1'b0, 0, 0, 0);
      chk("t0_trial_c2", 0, lg_trial[0][2], 8);
      chk("t0_trial_c5", 0, lg_trial[0][5], 1);
      chk("t0_result",   0, lg_result[0][6], 0);

      run(31, 1'b0, 1'b0, 0, 0, 0);
      chk("t31_trial_c3", 0, lg_trial[0][3], 28);
      chk("t31_trial_c5", 0, lg_trial[0][5], 31);
      chk("t31_result",   0, lg_result[0][6], 31);

      // illegal flags at the first sample point
      run(20, 1'b0, 1'b1, 0, 0, 0);
      chk("bad_done_cyc", 0, first_done(0), 2);
      chk("bad_err",      0, lg_err[0][2], 1);
      chk("bad_result",   0, lg_result[0][2], 0);
      chk("bad_lat2_done_cyc", 2, first_done(2), 4);

      // next start clears err; extra starts while busy / in finish are ignored
      run(20, 1'b0, 1'b0, 2, 4, 0);
      chk("clr_err_c1",     0, lg_err[0][1], 0);
      chk("xs_trial_c2",    0, lg_trial[0][2], 24);
      chk("xs_done_cnt",    0, count_done(0), 1);
      chk("xs_result",      0, lg_result[0][4], 20);
      chk("xs_no_restart",  0, lg_busy[0][5], 0);

      // reset in the middle of a search
      run(20, 1'b0, 1'b0, 0, 0, 2);
      chk("rst_mid_busy",   0, lg_busy[0][3], 0);
      chk("rst_mid_trial",  0, lg_trial[0][3], 0);
      chk("rst_mid_result", 0, lg_result[0][3], 0);
      chk("rst_mid_done",   0, count_done(0) + count_done(1) + count_done(2), 0);

      // start together with rst: rst wins
      rst   = 1'b1;
      start = 1'b1;
      tick();
      chk("rst_start_busy", 0, int'(a_busy[0]), 0);
      rst   = 1'b0;
      start = 1'b0;
      tick();

      repeat (60) begin
         int tg, xa, ra;
         bit gl, bd;
         tg = $urandom_range(0, 31);
         gl = ($urandom_range(0, 1) == 1);
         bd = ($urandom_range(0, 7) == 0);
         xa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0;
         ra = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 15) : 0;
         run(tg, gl, bd, xa, 0, ra);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
